pipelined_alu: RTL

Parametrised multi-cycle successor to the single-cycle ALU in the datapath. It adds the full RV32I integer op set, an iterative multiplier and an iterative unsigned divider, and an equality flag valid for every op. A valid/ready handshake on both sides lets the control unit stall the pipeline while multi-cycle ops complete. It sits between the register-file read stage and writeback.

---
 rtl/pipelined_alu.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_alu.sv
// Multi-cycle RV32I-style integer ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish on acceptance; MUL/DIVU/REMU iterate one bit per cycle.
module pipelined_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRLSIG    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRLSIG-1:0]    ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [CTRLSIG-1:0] OP_ADD  = CTRLSIG'(4'd0);
  localparam logic [CTRLSIG-1:0] OP_SUB  = CTRLSIG'(4'd1);
  localparam logic [CTRLSIG-1:0] OP_AND  = CTRLSIG'(4'd2);
  localparam logic [CTRLSIG-1:0] OP_OR   = CTRLSIG'(4'd3);
  localparam logic [CTRLSIG-1:0] OP_XOR  = CTRLSIG'(4'd4);
  localparam logic [CTRLSIG-1:0] OP_SLL  = CTRLSIG'(4'd5);
  localparam logic [CTRLSIG-1:0] OP_SRL  = CTRLSIG'(4'd6);
  localparam logic [CTRLSIG-1:0] OP_SRA  = CTRLSIG'(4'd7);
  localparam logic [CTRLSIG-1:0] OP_SLT  = CTRLSIG'(4'd8);
  localparam logic [CTRLSIG-1:0] OP_SLTU = CTRLSIG'(4'd9);
  localparam logic [CTRLSIG-1:0] OP_MUL  = CTRLSIG'(4'd10);
  localparam logic [CTRLSIG-1:0] OP_DIVU = CTRLSIG'(4'd11);
  localparam logic [CTRLSIG-1:0] OP_REMU = CTRLSIG'(4'd12);

  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CTRLSIG-1:0]      op_q, op_d;
  logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;   // MUL: multiplicand, DIV: dividend/quotient
  logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;   // MUL: multiplier,   DIV: divisor
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;     // MUL: partial sum,  DIV: partial remainder
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   alu_out_q, alu_out_d;
  logic                    eq_q, eq_d;
  logic                    out_valid_q, out_valid_d;

  logic [SHW-1:0]          shamt_s;
  logic [DATA_WIDTH-1:0]   alu_res_s;
  logic                    is_multi_s;
  logic [DATA_WIDTH-1:0]   mul_acc_s;
  logic [DATA_WIDTH:0]     div_sh_s;
  logic [DATA_WIDTH:0]     div_diff_s;
  logic                    div_ge_s;
  logic [DATA_WIDTH-1:0]   div_rem_s;
  logic [DATA_WIDTH-1:0]   div_quo_s;

  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign ALUout    = alu_out_q;
  assign EQ        = eq_q;

  assign shamt_s    = ALUop2[SHW-1:0];
  assign is_multi_s = (ALUctrl == OP_MUL) || (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);

  // Single-cycle result from the live operands
  always_comb begin
    alu_res_s = ZERO;
    case (ALUctrl)
      OP_ADD:  alu_res_s = ALUop1 + ALUop2;
      OP_SUB:  alu_res_s = ALUop1 - ALUop2;
      OP_AND:  alu_res_s = ALUop1 & ALUop2;
      OP_OR:   alu_res_s = ALUop1 | ALUop2;
      OP_XOR:  alu_res_s = ALUop1 ^ ALUop2;
      OP_SLL:  alu_res_s = ALUop1 << shamt_s;
      OP_SRL:  alu_res_s = ALUop1 >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(ALUop1) >>> shamt_s);
      OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
      default: alu_res_s = ZERO;
    endcase
  end

  // One shift-add / restoring-division step on the working registers
  always_comb begin
    mul_acc_s  = acc_q + (op_b_q[0] ? op_a_q : ZERO);
    div_sh_s   = {acc_q, op_a_q[DATA_WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, op_b_q};
    div_ge_s   = ~div_diff_s[DATA_WIDTH];
    div_rem_s  = div_ge_s ? div_diff_s[DATA_WIDTH-1:0] : div_sh_s[DATA_WIDTH-1:0];
    div_quo_s  = {op_a_q[DATA_WIDTH-2:0], div_ge_s};
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    alu_out_d   = alu_out_q;
    eq_d        = eq_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = ALUctrl;
          eq_d = (ALUop1 == ALUop2);
          if (is_multi_s) begin
            op_a_d  = ALUop1;
            op_b_d  = ALUop2;
            acc_d   = ZERO;
            cnt_d   = CW'(DATA_WIDTH);
            state_d = ST_BUSY;
          end else begin
            alu_out_d   = alu_res_s;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d  = mul_acc_s;
          op_a_d = op_a_q << 1;
          op_b_d = op_b_q >> 1;
        end else begin
          acc_d  = div_rem_s;
          op_a_d = div_quo_s;
        end
        if (cnt_q == CW'(1)) begin
          if (op_q == OP_MUL) begin
            alu_out_d = mul_acc_s;
          end else if (op_q == OP_DIVU) begin
            alu_out_d = div_quo_s;
          end else begin
            alu_out_d = div_rem_s;
          end
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= {CTRLSIG{1'b0}};
      op_a_q      <= ZERO;
      op_b_q      <= ZERO;
      acc_q       <= ZERO;
      cnt_q       <= {CW{1'b0}};
      alu_out_q   <= ZERO;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      alu_out_q   <= alu_out_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
